// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial compare scheduler and its MSB-first comparator core.
// SERIAL_CMP_EARLY_EXIT_EN (optional) is consumed by serial_cmp_scheduler.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMP_LESS    = 2'd0,
        CMP_EQ      = 2'd1,
        CMP_GREATER = 2'd2
    } cmp_res_t;

endpackage

// File: rtl/serial_cmp_msb_core.sv
// Bit-serial magnitude comparator, MSB first: result latches at the first
// differing bit and stays frozen until clr/rst return it to CMP_EQ.
module serial_cmp_msb_core
    import serial_cmp_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     clr,
    input  logic     en,
    input  logic     a,
    input  logic     b,
    output cmp_res_t res
);

    cmp_res_t r_res;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_res <= CMP_EQ;
        end else if (en && (r_res == CMP_EQ) && (a != b)) begin
            r_res <= a ? CMP_GREATER : CMP_LESS;
        end
    end

    assign res = r_res;

endmodule

// File: rtl/serial_cmp_scheduler.sv
// Round-robin scheduler sharing one serial comparator among N_REQ requesters.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish as soon as the result is decided.
module serial_cmp_scheduler
    import serial_cmp_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*W-1:0]        req_a,
    input  logic [N_REQ*W-1:0]        req_b,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      busy,
    output logic                      resp_valid,
    output logic [$clog2(N_REQ)-1:0]  resp_id,
    output logic                      resp_less,
    output logic                      resp_eq,
    output logic                      resp_greater
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(W + 1);

    state_t          r_state, w_state_nxt;
    logic [W-1:0]    r_a, r_b, w_sel_a, w_sel_b;
    logic [ID_W-1:0] r_grant, r_last_grant, r_id_hold, w_gidx;
    logic [CNT_W-1:0] r_cnt;
    logic            w_found, w_accept;
    logic [N_REQ-1:0] w_ready;
    cmp_res_t        w_res;
    logic            w_less, w_eq, w_greater;
    logic            r_less_hold, r_eq_hold, r_gt_hold;

    // Search starts one past the last granted requester and wraps.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            if (!w_found && req_valid[ID_W'((32'(r_last_grant) + k) % N_REQ)]) begin
                w_found = 1'b1;
                w_gidx  = ID_W'((32'(r_last_grant) + k) % N_REQ);
            end
        end
        w_accept = (r_state == IDLE) && w_found && !rst;
        w_ready  = '0;
        if (w_accept) begin
            w_ready[w_gidx] = 1'b1;
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_gidx == ID_W'(i)) begin
                w_sel_a = req_a[i*W +: W];
                w_sel_b = req_b[i*W +: W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_state_nxt = SHIFT;
            SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = DONE;
                end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                else if ((w_res == CMP_EQ) && (r_a[W-1] != r_b[W-1])) begin
                    w_state_nxt = DONE;
                end
`endif
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_grant      <= '0;
            r_last_grant <= ID_W'(N_REQ - 1);
            r_id_hold    <= '0;
            r_cnt        <= '0;
            r_less_hold  <= 1'b0;
            r_eq_hold    <= 1'b0;
            r_gt_hold    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_grant <= w_gidx;
                        r_cnt   <= CNT_W'(W);
                    end
                end
                SHIFT: begin
                    r_a   <= {r_a[W-2:0], 1'b0};
                    r_b   <= {r_b[W-2:0], 1'b0};
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                DONE: begin
                    r_last_grant <= r_grant;
                    r_id_hold    <= r_grant;
                    r_less_hold  <= w_less;
                    r_eq_hold    <= w_eq;
                    r_gt_hold    <= w_greater;
                end
                default: ;
            endcase
        end
    end

    serial_cmp_msb_core u_core (
        .clk (clk),
        .rst (rst),
        .clr (w_accept),
        .en  (r_state == SHIFT),
        .a   (r_a[W-1]),
        .b   (r_b[W-1]),
        .res (w_res)
    );

    assign w_less    = (w_res == CMP_LESS);
    assign w_eq      = (w_res == CMP_EQ);
    assign w_greater = (w_res == CMP_GREATER);

    // The core is cleared on the next accept, so the answer is held for later reads.
    assign req_ready    = w_ready;
    assign busy         = (r_state != IDLE);
    assign resp_valid   = (r_state == DONE);
    assign resp_id      = resp_valid ? r_grant   : r_id_hold;
    assign resp_less    = resp_valid ? w_less    : r_less_hold;
    assign resp_eq      = resp_valid ? w_eq      : r_eq_hold;
    assign resp_greater = resp_valid ? w_greater : r_gt_hold;

endmodule

// File: tb/tb_serial_cmp_scheduler.sv
// Self-checking bench for serial_cmp_scheduler; expected latency follows
// SERIAL_CMP_EARLY_EXIT_EN when the bench is built with that macro.
module tb_serial_cmp_scheduler;

    localparam int N = 4;
    localparam int W = 16;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             busy;
    logic             resp_valid;
    logic [1:0]       resp_id;
    logic             resp_less;
    logic             resp_eq;
    logic             resp_greater;

    serial_cmp_scheduler #(.N_REQ(N), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .busy         (busy),
        .resp_valid   (resp_valid),
        .resp_id      (resp_id),
        .resp_less    (resp_less),
        .resp_eq      (resp_eq),
        .resp_greater (resp_greater)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] v;
    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];
    int           last_model;
    int           prev_acc;
    int           lat_prev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = opa[i];
            req_b[i*W +: W] = opb[i];
        end
        req_valid = v;
        #1;
    endtask

    // Position (1-based, from MSB) of the first differing bit decides early finish.
    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        for (int j = W - 1; j >= 0; j--) begin
            if (a[j] != b[j]) return (W - j) + 1;
        end
        return W + 1;
`else
        return W + 1;
`endif
    endfunction

    function automatic int pick;
        for (int k = 1; k <= N; k++) begin
            if (v[(last_model + k) % N]) return (last_model + k) % N;
        end
        return 0;
    endfunction

    task automatic rand_pair(input int i);
        int sel;
        opa[i] = W'($urandom);
        sel = int'($urandom_range(0, 3));
        if (sel == 0)      opb[i] = opa[i];
        else if (sel == 1) opb[i] = opa[i] ^ (W'(1) << $urandom_range(0, W - 1));
        else               opb[i] = W'($urandom);
    endtask

    task automatic serve(input bit keep, input int exp_space, input bit chk_busy, output int lat_o);
        int g, n, lat;
        logic [N-1:0] oh;
        logic [W-1:0] a, b;
        g = pick();
        oh = '0;
        oh[g] = 1'b1;
        n = 0;
        while (req_ready == '0 && n < 100) begin
            tick;
            n++;
        end
        chk("grant", 64'(req_ready), 64'(oh));
        if (exp_space > 0) chk("accept_spacing", 64'(cyc - prev_acc), 64'(exp_space));
        a = opa[g];
        b = opb[g];
        prev_acc = cyc;
        tick;
        if (keep) rand_pair(g);
        else v[g] = 1'b0;
        drive;
        lat = exp_lat(a, b);
        n = 1;
        while (!resp_valid && n < 60) begin
            if (chk_busy) chk("busy_shift", 64'(busy), 64'd1);
            tick;
            n++;
        end
        chk("latency", 64'(n), 64'(lat));
        chk("resp_id", 64'(resp_id), 64'(g));
        chk("resp_less", 64'(resp_less), 64'(a < b));
        chk("resp_eq", 64'(resp_eq), 64'(a == b));
        chk("resp_greater", 64'(resp_greater), 64'(a > b));
        if (chk_busy) chk("busy_done", 64'(busy), 64'd1);
        last_model = g;
        lat_o = lat;
        tick;
        chk("resp_drop", 64'(resp_valid), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_resp_id"}, 64'(resp_id), 64'd0);
        chk({tag, "_flags"}, 64'({resp_less, resp_eq, resp_greater}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [N-1:0] m;

        rst = 1'b1;
        v = '0;
        for (int i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        drive;
        tick;
        tick;
        v = 4'b0001;
        drive;
        chk_reset_outputs("reset");
        v = '0;
        drive;
        rst = 1'b0;
        tick;
        last_model = N - 1;
        prev_acc = 0;

        v = 4'b0001; opa[0] = 16'h4126; opb[0] = 16'h4646; drive;
        serve(1'b0, 0, 1'b0, lat);
        v = 4'b0100; opa[2] = 16'h4726; opb[2] = 16'h4726; drive;
        serve(1'b0, 0, 1'b1, lat);
        v = 4'b0010; opa[1] = 16'h8000; opb[1] = 16'h7FFF; drive;
        serve(1'b0, 0, 1'b0, lat);

        rst = 1'b1;
        tick;
        rst = 1'b0;
        last_model = N - 1;
        v = 4'b1111;
        for (int i = 0; i < N; i++) rand_pair(i);
        drive;
        serve(1'b1, 0, 1'b0, lat_prev);
        for (int r = 0; r < 4; r++) begin
            serve(1'b1, lat_prev + 1, 1'b0, lat);
            lat_prev = lat;
        end
        v = '0;
        drive;
        tick;

        for (int r = 0; r < 12; r++) begin
            m = N'($urandom);
            if ((v | m) == '0) m = N'(1) << $urandom_range(0, N - 1);
            for (int i = 0; i < N; i++) begin
                if (m[i] && !v[i]) rand_pair(i);
            end
            v = v | m;
            drive;
            serve(1'b0, 0, 1'b0, lat);
        end
        v = '0;
        drive;
        tick;

        rst = 1'b1;
        tick;
        rst = 1'b0;
        last_model = N - 1;
        v = 4'b1000;
        opa[3] = W'($urandom);
        opb[3] = opa[3];
        drive;
        chk("abort_grant", 64'(req_ready), 64'b1000);
        tick;
        v = 4'b1010;
        rand_pair(1);
        rand_pair(3);
        drive;
        for (int t = 0; t < 4; t++) begin
            chk("abort_no_resp", 64'(resp_valid), 64'd0);
            chk("abort_busy", 64'(busy), 64'd1);
            tick;
        end
        rst = 1'b1;
        #1;
        tick;
        chk_reset_outputs("abort");
        rst = 1'b0;
        drive;
        last_model = N - 1;
        serve(1'b0, 0, 1'b0, lat);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
